// File: rtl/arb_pkg.sv
// Shared constants for the two-input arbiter and its downstream 2:1 mux.
// SRC_A/SRC_B fix the select encoding both blocks agree on.
package arb_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter feeding a single output register.
// out_valid and last_grant together form the EMPTY/FULL control state.
module rr_arb2
  import arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic last_grant;
  logic load;
  logic grant_valid;
  logic grant_id;

  assign load = !out_valid || out_ready;

  // State register: output word, its source, and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      sel        <= SRC_A;
      last_grant <= SRC_B;
    end else if (grant_valid) begin
      out_valid  <= 1'b1;
      out_data   <= (grant_id == SRC_B) ? b_data : a_data;
      sel        <= grant_id;
      last_grant <= grant_id;
    end else if (load) begin
      out_valid  <= 1'b0;
    end
  end

  // Next-state: on a tie the source not served last time wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = SRC_A;
    if (load) begin
      if (a_valid && b_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (a_valid) begin
        grant_valid = 1'b1;
        grant_id    = SRC_A;
      end else if (b_valid) begin
        grant_valid = 1'b1;
        grant_id    = SRC_B;
      end
    end
  end

  // Outputs: readies are masked during reset so no transfer is reported.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst && grant_valid) begin
      a_ready = (grant_id == SRC_A);
      b_ready = (grant_id == SRC_B);
    end
  end

  sat_cnt #(.CNT_W(CNT_W)) u_cnt_a (
    .clk (clk),
    .rst (rst),
    .inc (a_ready),
    .cnt (cnt_a)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_cnt_b (
    .clk (clk),
    .rst (rst),
    .inc (b_ready),
    .cnt (cnt_b)
  );

endmodule
